// File: rtl/ncl_dr_enable_reg.sv
// rtl/ncl_dr_enable_reg.sv - clocked dual-rail NCL enable register with phase-gated capture
//
// Captures a complete WIDTH-bit dual-rail DATA word when the PH_SEL rail of the
// one-hot phase bus is high and downstream requests DATA (ki=1). The word is held
// until the input returns to NULL and downstream requests NULL (ki=0).
// Illegal codewords raise a sticky err flag and are never captured.
//
// Optional feature macro: NCL_ENREG_ERRCNT_EN
//   When defined, this adds an 8-bit saturating count of cycles that had an illegal input.
//
// Ports:
//   clk       in   clock, rising-edge
//   rst       in   synchronous reset, active-high
//   a_t/a_f   in   true/false rails of the input word
//   ph_t      in   one-hot phase rails (all zero = NULL)
//   ki        in   downstream ack: 1 = request DATA, 0 = request NULL
//   o_t/o_f   out  true/false rails of the output word
//   ko        out  upstream ack: 1 = ready for DATA, 0 = ready for NULL
//   err       out  sticky illegal-codeword flag
//   wave_cnt  out  number of DATA wavefronts captured (wraps)
//   err_cnt   out  saturating illegal-cycle count (NCL_ENREG_ERRCNT_EN only)
module ncl_dr_enable_reg #(
   parameter int WIDTH  = 4,
   parameter int NUM_PH = 4,
   parameter int PH_SEL = 0,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  a_t,
   input  logic [WIDTH-1:0]  a_f,
   input  logic [NUM_PH-1:0] ph_t,
   input  logic              ki,
   output logic [WIDTH-1:0]  o_t,
   output logic [WIDTH-1:0]  o_f,
   output logic              ko,
   output logic              err,
`ifdef NCL_ENREG_ERRCNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic [CNT_W-1:0]  wave_cnt
);

   generate
      if (PH_SEL >= NUM_PH) begin : g_bad_ph_sel
         $error("ncl_dr_enable_reg: PH_SEL must be below NUM_PH");
      end
   endgenerate

   typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

   state_t state, state_nxt;

   logic in_data;
   logic in_null;
   logic illegal;
   logic capture;
   logic release_w;

   // A bit is a valid DATA bit when exactly one rail is high.
   assign in_data = &(a_t ^ a_f);
   assign in_null = (a_t == '0) && (a_f == '0) && (ph_t == '0);
   // x & (x-1) clears the lowest set bit; a non-zero result means more than one phase is high.
   assign illegal = (|(a_t & a_f)) || ((ph_t & (ph_t - 1'b1)) != '0);

   assign capture   = (state == S_NULL) && in_data && ph_t[PH_SEL] && !illegal && ki;
   assign release_w = (state == S_DATA) && in_null && !ki;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_NULL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_NULL:  if (capture)   state_nxt = S_DATA;
         S_DATA:  if (release_w) state_nxt = S_NULL;
         default: state_nxt = S_NULL;
      endcase
   end

   // Output logic: ko reflects which wavefront the register is ready to accept next.
   always_comb begin
      ko = 1'b1;
      if (state == S_DATA) ko = 1'b0;
   end

   // The captured word is registered; it is held through all of S_DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_t      <= '0;
         o_f      <= '0;
         wave_cnt <= '0;
      end else if (capture) begin
         o_t      <= a_t;
         o_f      <= a_f;
         wave_cnt <= wave_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (release_w) begin
         o_t      <= '0;
         o_f      <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (illegal) begin
         err <= 1'b1;
      end
   end

`ifdef NCL_ENREG_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (illegal && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ncl_dr_enable_reg.sv
// tb/tb_ncl_dr_enable_reg.sv - table-driven self-checking bench for ncl_dr_enable_reg
module tb_ncl_dr_enable_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a_t, a_f, ph_t;
   logic       ki;
   logic [3:0] o_t, o_f;
   logic       ko, err;
   logic [7:0] wave_cnt;
`ifdef NCL_ENREG_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ncl_dr_enable_reg #(.WIDTH(4), .NUM_PH(4), .PH_SEL(0), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_t      (a_t),
      .a_f      (a_f),
      .ph_t     (ph_t),
      .ki       (ki),
      .o_t      (o_t),
      .o_f      (o_f),
      .ko       (ko),
      .err      (err),
`ifdef NCL_ENREG_ERRCNT_EN
      .err_cnt  (err_cnt),
`endif
      .wave_cnt (wave_cnt)
   );

   typedef struct {
      logic       rst;
      logic [3:0] a_t;
      logic [3:0] a_f;
      logic [3:0] ph;
      logic       ki;
      logic [3:0] eo_t;
      logic [3:0] eo_f;
      logic       eko;
      logic       eerr;
      logic [7:0] ecnt;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] t, input logic [3:0] f,
                        input logic [3:0] p, input logic k);
      @(negedge clk);
      rst  = r;
      a_t  = t;
      a_f  = f;
      ph_t = p;
      ki   = k;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [3:0] et, input logic [3:0] ef,
                          input logic eko, input logic eerr, input logic [7:0] ecnt);
      chk({name, ".o_t"}, {28'd0, o_t}, {28'd0, et});
      chk({name, ".o_f"}, {28'd0, o_f}, {28'd0, ef});
      chk({name, ".ko"}, {31'd0, ko}, {31'd0, eko});
      chk({name, ".err"}, {31'd0, err}, {31'd0, eerr});
      chk({name, ".wave_cnt"}, {24'd0, wave_cnt}, {24'd0, ecnt});
   endtask

   initial begin
      rst = 1'b1; a_t = '0; a_f = '0; ph_t = '0; ki = 1'b1;

      //           rst   a_t      a_f      ph       ki    eo_t     eo_f     eko   eerr  ecnt
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0}; // reset
      vecs[1]  = '{1'b0, 4'b1010, 4'b0101, 4'b0001, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 8'd1}; // capture
      vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 8'd1}; // null, ki=1 hold
      vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 8'd1};
      vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 8'd1};
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1}; // release
      vecs[6]  = '{1'b0, 4'b1010, 4'b0101, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1}; // wrong phase
      vecs[7]  = '{1'b0, 4'b1010, 4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1}; // no phase
      vecs[8]  = '{1'b0, 4'b1010, 4'b0101, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1}; // ki=0
      vecs[9]  = '{1'b0, 4'b1010, 4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1}; // partial
      vecs[10] = '{1'b0, 4'b0110, 4'b1001, 4'b0001, 1'b1, 4'b0110, 4'b1001, 1'b0, 1'b0, 8'd2}; // capture
      vecs[11] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0110, 4'b1001, 1'b0, 1'b0, 8'd2}; // new data: hold
      vecs[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0110, 4'b1001, 1'b0, 1'b0, 8'd2}; // ki=0 not null
      vecs[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd2}; // release
      vecs[14] = '{1'b0, 4'b1110, 4'b0101, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'd2}; // bit2 both
      vecs[15] = '{1'b0, 4'b0011, 4'b1100, 4'b0001, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b1, 8'd3}; // err sticky
      vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b1, 8'd3}; // two-hot phase
      vecs[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0}; // rst clears
      vecs[18] = '{1'b0, 4'b1010, 4'b0101, 4'b0001, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 8'd1};
      vecs[19] = '{1'b1, 4'b1010, 4'b0101, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0}; // rst in DATA
      vecs[20] = '{1'b0, 4'b1010, 4'b0101, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'd0}; // two-hot incl sel
      vecs[21] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0};

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].a_t, vecs[i].a_f, vecs[i].ph, vecs[i].ki);
         chk_all($sformatf("vec%0d", i), vecs[i].eo_t, vecs[i].eo_f,
                 vecs[i].eko, vecs[i].eerr, vecs[i].ecnt);
      end

      // 256 DATA/NULL wavefronts starting from a fresh reset: counter reaches 255 then wraps to 0.
      begin
         int bad_rails = 0;
         for (int n = 1; n <= 256; n++) begin
            drive(1'b0, 4'b0101, 4'b1010, 4'b0001, 1'b1);
            if ((o_t & o_f) != 4'b0000) bad_rails++;
            if (n == 255) chk("wrap.cnt255", {24'd0, wave_cnt}, 32'd255);
            if (n == 256) chk("wrap.cnt0", {24'd0, wave_cnt}, 32'd0);
            drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            if ((o_t & o_f) != 4'b0000) bad_rails++;
         end
         chk("wrap.rails_exclusive", bad_rails, 32'd0);
         chk_all("wrap.end", 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0);
      end

      // Capture, then reset while the word is still held and the input still shows DATA.
      drive(1'b0, 4'b1100, 4'b0011, 4'b0001, 1'b1);
      chk_all("mid.capture", 4'b1100, 4'b0011, 1'b0, 1'b0, 8'd1);
      drive(1'b1, 4'b1100, 4'b0011, 4'b0001, 1'b1);
      chk_all("mid.rst", 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0);

`ifdef NCL_ENREG_ERRCNT_EN
      chk("errcnt.reset", {24'd0, err_cnt}, 32'd0);
      for (int n = 0; n < 300; n++) begin
         drive(1'b0, 4'b1111, 4'b1111, 4'b0001, 1'b1);
         if (n == 9) chk("errcnt.10", {24'd0, err_cnt}, 32'd10);
      end
      chk("errcnt.sat", {24'd0, err_cnt}, 32'd255);
      chk("errcnt.err", {31'd0, err}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
